two_out_of_five_scan_ctrl: RTL and testbench

Sequential front-end and display controller for the 2-out-of-5 decoder board. It synchronises and debounces the five code switches, commits a stable code word, and checks it for exactly two ones. It decodes a valid word to a digit, weighted 7-4-2-1-0. It time-multiplexes that digit's 5x7 glyph onto the LED matrix, one column at a time, with inter-column blanking. It sits between the raw switch pins and the matrix/column drivers, and exports the decoded digit and validity for the seven-segment path.

---
 rtl/two_out_of_five_scan_ctrl.sv | 158 +++++++++++++++
 tb/tb_two_out_of_five_scan_ctrl.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/two_out_of_five_scan_ctrl.sv
// 2-out-of-5 switch front end: synchronise, debounce, commit, decode (7-4-2-1-0)
// and column-scan the decoded digit's 5x7 glyph onto the LED matrix.
module two_out_of_five_scan_ctrl #(
    parameter int DIV = 50000,
    parameter int DEB = 1000000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [4:0] code_in,
    output logic [6:0] row,
    output logic [4:0] col,
    output logic [3:0] digit,
    output logic       valid,
    output logic       err,
    output logic       upd
);
    localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int CW = (DEB > 1) ? $clog2(DEB) : 1;
    localparam logic [PW-1:0] PRE_LAST = PW'(DIV - 1);
    localparam logic [CW-1:0] CNT_LAST = CW'(DEB - 1);

    logic [4:0]    sync1_reg, sync_reg, cand_reg, word_reg;
    logic [CW-1:0] cnt_reg;
    logic          pending_reg;
    logic [PW-1:0] pre_reg, pre_next;
    logic [2:0]    idx_reg, idx_next;
    logic [6:0]    row_reg, row_next;
    logic [4:0]    col_reg, col_next, col_onehot;
    logic [3:0]    digit_reg, dec_digit;
    logic          valid_reg, err_reg, upd_reg, dec_valid;
    logic [34:0]   glyph_bits;
    logic [6:0]    glyph_col;

    // Decode of the candidate word, used only at the commit edge.
    always_comb begin
        dec_valid = 1'b1;
        dec_digit = 4'hF;
        case (cand_reg)
            5'b11000: dec_digit = 4'd0;
            5'b00011: dec_digit = 4'd1;
            5'b00101: dec_digit = 4'd2;
            5'b00110: dec_digit = 4'd3;
            5'b01001: dec_digit = 4'd4;
            5'b01010: dec_digit = 4'd5;
            5'b01100: dec_digit = 4'd6;
            5'b10001: dec_digit = 4'd7;
            5'b10010: dec_digit = 4'd8;
            5'b10100: dec_digit = 4'd9;
            default:  dec_valid = 1'b0;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync1_reg   <= '0;
            sync_reg    <= '0;
            cand_reg    <= '0;
            cnt_reg     <= '0;
            word_reg    <= '0;
            pending_reg <= 1'b1;
            upd_reg     <= 1'b0;
            digit_reg   <= '0;
            valid_reg   <= 1'b0;
            err_reg     <= 1'b0;
        end else begin
            sync1_reg <= code_in;
            sync_reg  <= sync1_reg;
            upd_reg   <= 1'b0;
            if (sync_reg != cand_reg) begin
                cand_reg <= sync_reg;
                cnt_reg  <= '0;
            end else if (cnt_reg != CNT_LAST) begin
                cnt_reg <= cnt_reg + 1'b1;
            end
            // The first word after reset commits even if it matches the reset word.
            if (cnt_reg == CNT_LAST && (cand_reg != word_reg || pending_reg)) begin
                word_reg    <= cand_reg;
                pending_reg <= 1'b0;
                upd_reg     <= 1'b1;
                digit_reg   <= dec_digit;
                valid_reg   <= dec_valid;
                err_reg     <= ~dec_valid;
            end
        end
    end

    always_comb begin
        pre_next = pre_reg + 1'b1;
        idx_next = idx_reg;
        if (pre_reg == PRE_LAST) begin
            pre_next = '0;
            idx_next = (idx_reg == 3'd4) ? 3'd0 : idx_reg + 3'd1;
        end
    end

    generate
        for (genvar gi = 0; gi < 5; gi++) begin : g_onehot
            assign col_onehot[gi] = (idx_next == 3'(4 - gi));
        end
    endgenerate

    // Glyph columns packed left (c1) to right (c5), bit0 of each = top row.
    always_comb begin
        case (digit_reg)
            4'd0:    glyph_bits = {7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E};
            4'd1:    glyph_bits = {7'h00, 7'h42, 7'h7F, 7'h40, 7'h00};
            4'd2:    glyph_bits = {7'h42, 7'h61, 7'h51, 7'h49, 7'h46};
            4'd3:    glyph_bits = {7'h21, 7'h41, 7'h45, 7'h4B, 7'h31};
            4'd4:    glyph_bits = {7'h18, 7'h14, 7'h12, 7'h7F, 7'h10};
            4'd5:    glyph_bits = {7'h27, 7'h45, 7'h45, 7'h45, 7'h39};
            4'd6:    glyph_bits = {7'h3C, 7'h4A, 7'h49, 7'h49, 7'h30};
            4'd7:    glyph_bits = {7'h01, 7'h71, 7'h09, 7'h05, 7'h03};
            4'd8:    glyph_bits = {7'h36, 7'h49, 7'h49, 7'h49, 7'h36};
            4'd9:    glyph_bits = {7'h06, 7'h49, 7'h49, 7'h29, 7'h1E};
            default: glyph_bits = '0;
        endcase
        case (idx_next)
            3'd0:    glyph_col = glyph_bits[34:28];
            3'd1:    glyph_col = glyph_bits[27:21];
            3'd2:    glyph_col = glyph_bits[20:14];
            3'd3:    glyph_col = glyph_bits[13:7];
            default: glyph_col = glyph_bits[6:0];
        endcase
    end

    // Outputs are registered from the next scan position so col lines up with pre.
    always_comb begin
        col_next = '0;
        row_next = '0;
        if (pre_next != '0) begin
            col_next = col_onehot;
            if (valid_reg) begin
                row_next = glyph_col;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pre_reg <= '0;
            idx_reg <= '0;
            row_reg <= '0;
            col_reg <= '0;
        end else begin
            pre_reg <= pre_next;
            idx_reg <= idx_next;
            row_reg <= row_next;
            col_reg <= col_next;
        end
    end

    assign row   = row_reg;
    assign col   = col_reg;
    assign digit = digit_reg;
    assign valid = valid_reg;
    assign err   = err_reg;
    assign upd   = upd_reg;
endmodule

// File: tb/tb_two_out_of_five_scan_ctrl.sv
// Directed bench for two_out_of_five_scan_ctrl with DIV=4, DEB=4.
module tb_two_out_of_five_scan_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic [4:0] code_in;
    logic [6:0] row;
    logic [4:0] col;
    logic [3:0] digit;
    logic       valid, err, upd;

    int checks = 0;
    int failures = 0;

    two_out_of_five_scan_ctrl #(.DIV(4), .DEB(4)) dut (
        .clk(clk), .rst_n(rst_n), .code_in(code_in),
        .row(row), .col(col), .digit(digit),
        .valid(valid), .err(err), .upd(upd)
    );

    always #5 clk = ~clk;

    localparam logic [4:0] COL_T [12] = '{5'h10, 5'h10, 5'h10, 5'h00, 5'h08, 5'h08,
                                          5'h08, 5'h00, 5'h04, 5'h04, 5'h04, 5'h00};
    localparam logic [6:0] ROW_T [12] = '{7'h00, 7'h00, 7'h00, 7'h00, 7'h00, 7'h00,
                                          7'h00, 7'h00, 7'h49, 7'h49, 7'h49, 7'h00};
    localparam logic [4:0] VW [10] = '{5'b11000, 5'b00011, 5'b00101, 5'b00110, 5'b01001,
                                       5'b01010, 5'b01100, 5'b10001, 5'b10010, 5'b10100};

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic wait_upd(input int maxc, output int n);
        n = -1;
        for (int k = 1; k <= maxc; k++) begin
            step();
            if (upd === 1'b1) begin
                n = k;
                break;
            end
        end
    endtask

    task automatic count_upd(input int cyc, output int c);
        c = 0;
        for (int k = 0; k < cyc; k++) begin
            step();
            if (upd === 1'b1) c++;
        end
    endtask

    task automatic check_frame(input string tag, input logic [0:4][6:0] g);
        int found;
        logic [4:0] oh;
        found = 0;
        for (int k = 0; k < 25 && found == 0; k++) begin
            step();
            if (col === 5'b00001) found = 1;
        end
        for (int k = 0; k < 4 && found == 1; k++) begin
            step();
            if (col === 5'b00000) found = 2;
        end
        chk({tag, "_sync"}, found, 2);
        for (int c = 0; c < 5; c++) begin
            oh = 5'b10000 >> c;
            for (int k = 0; k < 3; k++) begin
                step();
                chk($sformatf("%s_col%0d", tag, c), col, oh);
                chk($sformatf("%s_row%0d", tag, c), row, g[c]);
            end
            step();
            chk($sformatf("%s_blank%0d", tag, c), {row, col}, 12'h000);
        end
    endtask

    task automatic commit(input string tag, input logic [4:0] w, input logic [3:0] d, input logic v);
        int n;
        code_in = w;
        wait_upd(20, n);
        chk({tag, "_lat"}, n, 7);
        chk({tag, "_digit"}, digit, d);
        chk({tag, "_valid"}, valid, v);
        chk({tag, "_err"}, err, !v);
        step();
        chk({tag, "_upd_width"}, upd, 0);
    endtask

    initial begin
        int n;
        logic [3:0] ed;
        logic ev;

        // Reset with 11000 already on the switches
        rst_n = 1'b0;
        code_in = 5'b11000;
        step(); step(); step();
        chk("rst_row", row, 0);
        chk("rst_col", col, 0);
        chk("rst_digit", digit, 0);
        chk("rst_valid", valid, 0);
        chk("rst_err", err, 0);
        chk("rst_upd", upd, 0);
        rst_n = 1'b1;
        for (int i = 0; i < 12; i++) begin
            step();
            chk($sformatf("boot_col%0d", i), col, COL_T[i]);
            chk($sformatf("boot_row%0d", i), row, ROW_T[i]);
            chk($sformatf("boot_upd%0d", i), upd, (i == 6) ? 1 : 0);
            chk($sformatf("boot_valid%0d", i), valid, (i >= 6) ? 1 : 0);
        end
        chk("boot_digit", digit, 0);
        check_frame("frame0", {7'h3E, 7'h51, 7'h49, 7'h45, 7'h3E});

        commit("d1", 5'b00011, 4'd1, 1'b1);
        check_frame("frame1", {7'h00, 7'h42, 7'h7F, 7'h40, 7'h00});
        count_upd(15, n);
        chk("hold_no_upd", n, 0);

        commit("inv", 5'b11100, 4'hF, 1'b0);
        check_frame("frame_inv", {7'h00, 7'h00, 7'h00, 7'h00, 7'h00});

        // Short glitch back to the committed word must not commit
        commit("d2", 5'b00101, 4'd2, 1'b1);
        code_in = 5'b00110;
        step(); step(); step();
        code_in = 5'b00101;
        count_upd(20, n);
        chk("glitch_no_upd", n, 0);
        chk("glitch_digit", digit, 2);
        commit("d3", 5'b00110, 4'd3, 1'b1);

        // Mid-frame reset with digit 9 committed
        commit("d9", 5'b10100, 4'd9, 1'b1);
        step(); step();
        rst_n = 1'b0;
        step();
        chk("mrst_row", row, 0);
        chk("mrst_col", col, 0);
        chk("mrst_digit", digit, 0);
        chk("mrst_valid", valid, 0);
        chk("mrst_err", err, 0);
        chk("mrst_upd", upd, 0);
        rst_n = 1'b1;
        step();
        chk("mrst_col_first", col, 5'b10000);
        wait_upd(20, n);
        chk("mrst_lat", n, 6);
        chk("mrst_digit9", digit, 9);
        chk("mrst_valid9", valid, 1);
        check_frame("frame9", {7'h06, 7'h49, 7'h49, 7'h29, 7'h1E});

        // All 32 words
        for (int w = 0; w < 32; w++) begin
            ed = 4'hF;
            ev = 1'b0;
            for (int j = 0; j < 10; j++) begin
                if (VW[j] == 5'(w)) begin
                    ed = 4'(j);
                    ev = 1'b1;
                end
            end
            commit($sformatf("sweep%02h", w), 5'(w), ed, ev);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
